alu_4bit_issuer: RTL and testbench



---
 rtl/alu_4bit_issuer.sv | 164 ++++++++++++++++
 tb/tb_alu_4bit_issuer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4bit_issuer.sv
// Command-side initiator for the combinational alu_4bit: buffers commands, issues one at a time,
// checks each ALU result against a golden model and returns tagged responses with running counters.
module alu_4bit_issuer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [2:0]       ALU_Sel,
    output logic [3:0]       a,
    output logic [3:0]       b,
    input  logic [3:0]       ALU_Result,
    input  logic             Zero,
    input  logic             Carry,
    input  logic             Overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 11 + TAG_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t             r_state, w_state_nxt;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [AW:0]        r_count;
    logic [TAG_W-1:0]   r_tag;
    logic               w_full, w_empty, w_push, w_pop, w_capture, w_accept, w_err;
    logic [EW-1:0]      w_head;

    function automatic logic [3:0] f_golden(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
        case (op)
            3'b000:  f_golden = x + y;
            3'b001:  f_golden = x - y;
            3'b010:  f_golden = x & y;
            3'b011:  f_golden = x | y;
            3'b100:  f_golden = x ^ y;
            3'b101:  f_golden = ~x;
            3'b110:  f_golden = {x[2:0], 1'b0};
            default: f_golden = {1'b0, x[3:1]};
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        f_sat_inc = (&c) ? c : c + CNT_W'(1);
    endfunction

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full && !rst;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_err     = (ALU_Result != f_golden(ALU_Sel, a, b)) || (Zero != (ALU_Result == 4'd0));

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ALU drive changes only on a pop, so the ALU inputs stay stable through ISSUE and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Sel <= '0;
            a       <= '0;
            b       <= '0;
            r_tag   <= '0;
        end else if (w_pop) begin
            ALU_Sel <= w_head[EW-1 -: 3];
            a       <= w_head[TAG_W+7 -: 4];
            b       <= w_head[TAG_W+3 -: 4];
            r_tag   <= w_head[TAG_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
            err_count  <= '0;
        end else begin
            if (w_capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= ALU_Result;
                rsp_flags  <= {Overflow, Carry, Zero};
                rsp_tag    <= r_tag;
                rsp_err    <= w_err;
            end else if (w_accept) begin
                rsp_valid <= 1'b0;
                op_count  <= f_sat_inc(op_count);
                if (rsp_err) err_count <= f_sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_alu_4bit_issuer.sv
// Self-checking bench for alu_4bit_issuer: behavioural ALU with fault override, table-driven
// vectors, and a response scoreboard filled on command acceptance.
module tb_alu_4bit_issuer;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] tag;
        logic [3:0] res;
        logic [2:0] flags;
        logic       err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a, cmd_b, cmd_tag;
    logic [2:0] ALU_Sel;
    logic [3:0] a, b;
    logic [3:0] ALU_Result;
    logic       Zero, Carry, Overflow;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_flags;
    logic [3:0] rsp_tag;
    logic       rsp_err;
    logic [15:0] op_count, err_count;

    logic       force_en = 1'b0;
    logic [3:0] m_res;
    logic [4:0] m_wide;
    logic       m_c, m_o;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_rsp = 0;
    vec_t sbq[$];
    vec_t tbl[10];
    vec_t v;

    always #5 clk = ~clk;

    alu_4bit_issuer #(.DEPTH(4), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .ALU_Sel(ALU_Sel), .a(a), .b(b),
        .ALU_Result(ALU_Result), .Zero(Zero), .Carry(Carry), .Overflow(Overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count)
    );

    // Behavioural alu_4bit; the fault override forces result 5 with Zero low.
    always_comb begin
        m_wide = 5'd0;
        m_res  = 4'd0;
        m_c    = 1'b0;
        m_o    = 1'b0;
        case (ALU_Sel)
            3'b000: begin
                m_wide = {1'b0, a} + {1'b0, b};
                m_res  = m_wide[3:0];
                m_c    = m_wide[4];
                m_o    = (a[3] == b[3]) && (m_res[3] != a[3]);
            end
            3'b001: begin
                m_wide = {1'b0, a} - {1'b0, b};
                m_res  = m_wide[3:0];
                m_c    = m_wide[4];
                m_o    = (a[3] != b[3]) && (m_res[3] != a[3]);
            end
            3'b010:  m_res = a & b;
            3'b011:  m_res = a | b;
            3'b100:  m_res = a ^ b;
            3'b101:  m_res = ~a;
            3'b110:  m_res = a << 1;
            default: m_res = a >> 1;
        endcase
    end
    assign ALU_Result = force_en ? 4'h5 : m_res;
    assign Zero       = force_en ? 1'b0 : (m_res == 4'd0);
    assign Carry      = m_c;
    assign Overflow   = m_o;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one command and waits (bounded) for it to be accepted; returns #1 after the accept edge.
    task automatic send(input vec_t cv);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd_op    = cv.op;
        cmd_a     = cv.a;
        cmd_b     = cv.b;
        cmd_tag   = cv.tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sbq.push_back(cv);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sbq.size() == 0 && !rsp_valid) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // Response monitor: in-order scoreboard plus hold-stability under back-pressure.
    initial begin
        bit          hold = 0;
        logic [11:0] snap = '0;
        vec_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete();
                n_rsp = 0;
                hold  = 0;
            end else begin
                if (hold && rsp_valid)
                    check("rsp_stable", {rsp_result, rsp_flags, rsp_tag, rsp_err}, snap);
                if (rsp_valid && rsp_ready) begin
                    if (sbq.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("rsp_tag", rsp_tag, e.tag);
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_flags", rsp_flags, e.flags);
                        check("rsp_err", rsp_err, e.err);
                    end
                    n_rsp++;
                    hold = 0;
                end else if (rsp_valid) begin
                    hold = 1;
                    snap = {rsp_result, rsp_flags, rsp_tag, rsp_err};
                end else begin
                    hold = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op      a      b      tag    res    {O,C,Z} err
        tbl[0] = '{3'b000, 4'd9, 4'd8, 4'd3, 4'd1, 3'b110, 1'b0};
        tbl[1] = '{3'b001, 4'd0, 4'd1, 4'd4, 4'hF, 3'b010, 1'b0};
        tbl[2] = '{3'b010, 4'hC, 4'hA, 4'd5, 4'h8, 3'b000, 1'b0};
        tbl[3] = '{3'b011, 4'hC, 4'hA, 4'd6, 4'hE, 3'b000, 1'b0};
        tbl[4] = '{3'b100, 4'd5, 4'd5, 4'd7, 4'h0, 3'b001, 1'b0};
        tbl[5] = '{3'b101, 4'd3, 4'd0, 4'd8, 4'hC, 3'b000, 1'b0};
        tbl[6] = '{3'b110, 4'h8, 4'd0, 4'd9, 4'h0, 3'b001, 1'b0};
        tbl[7] = '{3'b111, 4'h1, 4'd0, 4'hA, 4'h0, 3'b001, 1'b0};
        tbl[8] = '{3'b000, 4'd7, 4'd1, 4'hB, 4'h8, 3'b100, 1'b0};
        tbl[9] = '{3'b001, 4'h8, 4'd1, 4'hC, 4'h7, 3'b100, 1'b0};

        // Reset held two cycles with a command offered.
        rst = 1'b1; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 4'hF; cmd_b = 4'hF; cmd_tag = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_drive", {ALU_Sel, a, b}, 0);
        check("rst_rsp", {rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err}, 0);
        check("rst_counts", {op_count, err_count}, 0);
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_push", {rsp_valid, ALU_Sel, a, b}, 0);
        check("post_rst_opcount", op_count, 0);

        // Single ADD with cycle-exact latency.
        send(tbl[0]);
        @(posedge clk); #1;
        check("add_drive", {ALU_Sel, a, b}, {3'b000, 4'd9, 4'd8});
        check("add_not_yet_valid", rsp_valid, 0);
        @(posedge clk); #1;
        check("add_valid", rsp_valid, 1);
        check("add_result", rsp_result, 1);
        check("add_carry_zero", {rsp_flags[1], rsp_flags[0]}, 2'b10);
        check("add_tag", rsp_tag, 3);
        check("add_err", rsp_err, 0);
        @(posedge clk); #1;
        check("add_opcount", op_count, 1);
        check("add_valid_cleared", rsp_valid, 0);

        // Remaining table vectors, back-to-back, including shift and subtract boundaries.
        for (int i = 1; i < 10; i++) send(tbl[i]);
        wait_drain();
        check("table_opcount", op_count, n_rsp);
        check("table_errcount", err_count, 0);

        // Back-pressure: fill the FIFO behind a stalled response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v = '{3'b010, 4'(i), 4'hF, 4'(i), 4'(i), {2'b00, i == 0}, 1'b0};
            send(v);
        end
        check("bp_full_ready", cmd_ready, 0);
        check("bp_head_valid", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
        cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 4'd5; cmd_b = 4'hF; cmd_tag = 4'd5;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_stall_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        v = '{3'b010, 4'd5, 4'hF, 4'd5, 4'd5, 3'b000, 1'b0};
        send(v);
        wait_drain();
        check("bp_opcount", op_count, n_rsp);

        // Fault injection followed by the same operation on a healthy ALU.
        force_en = 1'b1;
        v = '{3'b100, 4'd5, 4'd5, 4'd7, 4'h5, 3'b000, 1'b1};
        send(v);
        wait_drain();
        force_en = 1'b0;
        check("fault_errcount", err_count, 1);
        v = '{3'b100, 4'd5, 4'd5, 4'd8, 4'h0, 3'b001, 1'b0};
        send(v);
        wait_drain();
        check("healthy_errcount", err_count, 1);
        check("healthy_opcount", op_count, n_rsp);

        // Reset while a response is held and two commands are queued.
        rsp_ready = 1'b0;
        for (int i = 2; i < 5; i++) send(tbl[i]);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        check("mid_valid_before_rst", rsp_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_counts", {op_count, err_count}, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mid_no_rsp", rsp_valid, 0);
        check("mid_opcount", op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
